instruction_decoder: RTL and testbench



---
 rtl/instruction_decoder_pkg.sv | 80 ++++++++
 rtl/instruction_decoder_sync_fifo.sv | 66 ++++++
 rtl/instruction_decoder.sv | 169 ++++++++++++++++
 tb/tb_instruction_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decoder_pkg.sv
// Shared definitions for the instruction decoder: opcode values, field
// positions inside the 64-bit instruction word, FSM states and helpers that
// classify and split a raw word. The program counter and array sequencer use
// the same package so all three agree on the encoding.
package instruction_decoder_pkg;

  // Instruction word geometry
  localparam int INSTR_WIDTH   = 64;
  localparam int OPCODE_WIDTH  = 4;
  localparam int FIELD_WIDTH   = 16;

  localparam int OPCODE_MSB    = 63;
  localparam int OPCODE_LSB    = 60;
  localparam int RESERVED_MSB  = 59;
  localparam int RESERVED_LSB  = 48;
  localparam int ADDR_A_MSB    = 47;
  localparam int ADDR_A_LSB    = 32;
  localparam int ADDR_B_MSB    = 31;
  localparam int ADDR_B_LSB    = 16;
  localparam int COUNT_MSB     = 15;
  localparam int COUNT_LSB     = 0;

  // Opcode encoding; 0x5..0xE are reserved and treated as illegal
  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP         = 4'h0,
    OP_LOAD_WEIGHT = 4'h1,
    OP_LOAD_DATA   = 4'h2,
    OP_COMPUTE     = 4'h3,
    OP_STORE       = 4'h4,
    OP_HALT        = 4'hF
  } opcode_e;

  // Decoder run state
  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_e;

  // What the decoder must do with the word at the FIFO head
  typedef enum logic [1:0] {
    HEAD_NOP,
    HEAD_ISSUE,
    HEAD_HALT,
    HEAD_ILLEGAL
  } head_kind_e;

  // Decoded command as presented to the array sequencer
  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [FIELD_WIDTH-1:0]  addr_a;
    logic [FIELD_WIDTH-1:0]  addr_b;
    logic [FIELD_WIDTH-1:0]  count;
  } command_t;

  // Map a raw opcode onto the action the head processor takes
  function automatic head_kind_e classify_opcode(input logic [OPCODE_WIDTH-1:0] op);
    head_kind_e kind;
    case (op)
      OP_NOP:         kind = HEAD_NOP;
      OP_LOAD_WEIGHT,
      OP_LOAD_DATA,
      OP_COMPUTE,
      OP_STORE:       kind = HEAD_ISSUE;
      OP_HALT:        kind = HEAD_HALT;
      default:        kind = HEAD_ILLEGAL;
    endcase
    return kind;
  endfunction

  // Split a raw word into its command fields; the reserved bits are dropped
  function automatic command_t split_fields(input logic [INSTR_WIDTH-1:0] word);
    command_t cmd;
    cmd.opcode = word[OPCODE_MSB:OPCODE_LSB];
    cmd.addr_a = word[ADDR_A_MSB:ADDR_A_LSB];
    cmd.addr_b = word[ADDR_B_MSB:ADDR_B_LSB];
    cmd.count  = word[COUNT_MSB:COUNT_LSB];
    return cmd;
  endfunction

endpackage

// File: rtl/instruction_decoder_sync_fifo.sv
// Generic single-clock FIFO with a registered occupancy count. The head entry
// is visible on dout whenever empty is low (show-ahead), so a consumer can
// inspect it and pop in the same cycle. Pushing while full and popping while
// empty are ignored. Used by the instruction decoder and reusable for the
// array data paths.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH:0]   occupancy;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (occupancy == FULL_COUNT);
  assign empty = (occupancy == '0);
  assign dout  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // occupancy unchanged
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/instruction_decoder.sv
// Decode and issue stage sitting between the program counter and the array
// sequencer. Raw words are buffered in a small FIFO; one head entry is
// processed per cycle. Issuable opcodes are loaded into a registered output
// stage with a valid/ready handshake, NOPs are dropped, illegal opcodes set a
// sticky flag, and HALT parks the decoder until a resume pulse arrives.
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter int INSTRUCTION_SIZE = 64,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [INSTRUCTION_SIZE-1:0] in_instruction,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [3:0]                  out_opcode,
  output logic [15:0]                 out_addr_a,
  output logic [15:0]                 out_addr_b,
  output logic [15:0]                 out_count,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        resume,
  output logic                        halted,
  output logic                        illegal_op,
  output logic [15:0]                 issued_count
);

  // Elaboration guard: the field layout only fits a 64-bit word and the FIFO
  // pointers rely on a power-of-two depth of at least two
  if (INSTRUCTION_SIZE != INSTR_WIDTH) begin : g_bad_width
    $error("instruction_decoder: INSTRUCTION_SIZE must be 64");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instruction_decoder: FIFO_DEPTH must be a power of two >= 2");
  end

  state_e                      state;
  state_e                      next_state;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [INSTRUCTION_SIZE-1:0] fifo_head;
  command_t                    head_cmd;
  head_kind_e                  head_kind;
  logic                        out_free;
  logic                        load_cmd;
  logic                        set_illegal;
  logic                        accepted;

  // Words are accepted only while running and with room in the buffer; the
  // reset term keeps in_ready low for as long as reset_n is held
  assign in_ready  = reset_n && !fifo_full && (state == ST_RUN);
  assign fifo_push = in_valid && in_ready;

  sync_fifo #(
    .WIDTH (INSTRUCTION_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (in_instruction),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_cmd  = split_fields(fifo_head);
  assign head_kind = classify_opcode(head_cmd.opcode);

  // The output register can take a new command when empty or being drained
  assign out_free = !out_valid || out_ready;
  assign accepted = out_valid && out_ready;

  // Run/halt state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // Head processing and next-state logic: decide whether the head pops, loads
  // the output stage, flags an illegal opcode or halts the decoder
  always_comb begin
    next_state  = state;
    fifo_pop    = 1'b0;
    load_cmd    = 1'b0;
    set_illegal = 1'b0;
    halted      = 1'b0;
    case (state)
      ST_RUN: begin
        if (!fifo_empty) begin
          case (head_kind)
            HEAD_NOP: begin
              fifo_pop = 1'b1;
            end
            HEAD_ISSUE: begin
              if (out_free) begin
                fifo_pop = 1'b1;
                load_cmd = 1'b1;
              end
            end
            HEAD_HALT: begin
              fifo_pop   = 1'b1;
              next_state = ST_HALTED;
            end
            default: begin
              fifo_pop    = 1'b1;
              set_illegal = 1'b1;
            end
          endcase
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
        if (resume) begin
          next_state = ST_RUN;
        end
      end
      default: begin
        next_state = ST_RUN;
      end
    endcase
  end

  // Output register: load a freshly decoded command, otherwise hold it until
  // the sequencer accepts and then drop valid
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_addr_a <= '0;
      out_addr_b <= '0;
      out_count  <= '0;
    end else if (load_cmd) begin
      out_valid  <= 1'b1;
      out_opcode <= head_cmd.opcode;
      out_addr_a <= head_cmd.addr_a;
      out_addr_b <= head_cmd.addr_b;
      out_count  <= head_cmd.count;
    end else if (accepted) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      illegal_op <= 1'b0;
    end else if (set_illegal) begin
      illegal_op <= 1'b1;
    end
  end

  // Count of completed output handshakes, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issued_count <= '0;
    end else if (accepted) begin
      issued_count <= issued_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder. A transaction-level model keeps
// the buffered words in a queue and applies the opcode rules directly; every
// cycle the DUT outputs are compared against it. Directed sequences cover the
// reset, latency, full, NOP/illegal, halt/resume, mid-run reset and counter
// wrap cases, followed by a randomized run.
module tb_instruction_decoder;

  localparam logic [3:0] OPC_NOP     = 4'h0;
  localparam logic [3:0] OPC_LOAD_W  = 4'h1;
  localparam logic [3:0] OPC_LOAD_D  = 4'h2;
  localparam logic [3:0] OPC_COMPUTE = 4'h3;
  localparam logic [3:0] OPC_STORE   = 4'h4;
  localparam logic [3:0] OPC_HALT    = 4'hF;
  localparam int         DEPTH       = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] in_instruction;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_opcode;
  logic [15:0] out_addr_a;
  logic [15:0] out_addr_b;
  logic [15:0] out_count;
  logic        out_valid;
  logic        out_ready;
  logic        resume;
  logic        halted;
  logic        illegal_op;
  logic [15:0] issued_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [63:0] m_queue [$];
  bit          m_halted;
  bit          m_illegal;
  bit          m_out_valid;
  logic [3:0]  m_opcode;
  logic [15:0] m_addr_a;
  logic [15:0] m_addr_b;
  logic [15:0] m_count;
  int unsigned m_issued;

  always #5 clk = ~clk;

  instruction_decoder #(
    .INSTRUCTION_SIZE (64),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_instruction (in_instruction),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_opcode     (out_opcode),
    .out_addr_a     (out_addr_a),
    .out_addr_b     (out_addr_b),
    .out_count      (out_count),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .resume         (resume),
    .halted         (halted),
    .illegal_op     (illegal_op),
    .issued_count   (issued_count)
  );

  // Single comparison point for the whole bench
  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Build an instruction word with random reserved bits
  function automatic logic [63:0] make_word(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] c);
    logic [11:0] rsv;
    rsv = 12'($urandom);
    return {op, rsv, a, b, c};
  endfunction

  function automatic logic model_in_ready(input logic rst_n);
    return rst_n && (m_queue.size() < DEPTH) && !m_halted;
  endfunction

  // Advance the model by one clock edge given the inputs sampled at that edge
  task automatic model_step(input logic v, input logic [63:0] w, input logic ordy,
                            input logic res, input logic rst_n);
    bit          room;
    bit          accepted;
    bit          load;
    logic [63:0] head;
    logic [3:0]  op;
    if (!rst_n) begin
      m_queue.delete();
      m_halted    = 0;
      m_illegal   = 0;
      m_out_valid = 0;
      m_opcode    = '0;
      m_addr_a    = '0;
      m_addr_b    = '0;
      m_count     = '0;
      m_issued    = 0;
      return;
    end
    room     = (m_queue.size() < DEPTH) && !m_halted;
    accepted = m_out_valid && ordy;
    load     = 0;
    if (m_halted) begin
      if (res) m_halted = 0;
    end else if (m_queue.size() > 0) begin
      head = m_queue[0];
      op   = head[63:60];
      if (op == OPC_NOP) begin
        void'(m_queue.pop_front());
      end else if (op >= OPC_LOAD_W && op <= OPC_STORE) begin
        if (!m_out_valid || ordy) begin
          void'(m_queue.pop_front());
          load     = 1;
          m_opcode = op;
          m_addr_a = head[47:32];
          m_addr_b = head[31:16];
          m_count  = head[15:0];
        end
      end else if (op == OPC_HALT) begin
        void'(m_queue.pop_front());
        m_halted = 1;
      end else begin
        void'(m_queue.pop_front());
        m_illegal = 1;
      end
    end
    if (accepted) m_issued++;
    if (load) m_out_valid = 1;
    else if (accepted) m_out_valid = 0;
    if (v && room) m_queue.push_back(w);
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and all
  // registered outputs after it against the model
  task automatic apply_stimulus(input logic v, input logic [63:0] w, input logic ordy,
                                input logic res, input logic rst_n);
    in_valid       = v;
    in_instruction = w;
    out_ready      = ordy;
    resume         = res;
    reset_n        = rst_n;
    #1;
    check_output("in_ready", {63'd0, in_ready}, {63'd0, model_in_ready(rst_n)});
    @(posedge clk);
    model_step(v, w, ordy, res, rst_n);
    @(negedge clk);
    check_output("out_valid", {63'd0, out_valid}, {63'd0, m_out_valid});
    check_output("out_opcode", {60'd0, out_opcode}, {60'd0, m_opcode});
    check_output("out_addr_a", {48'd0, out_addr_a}, {48'd0, m_addr_a});
    check_output("out_addr_b", {48'd0, out_addr_b}, {48'd0, m_addr_b});
    check_output("out_count", {48'd0, out_count}, {48'd0, m_count});
    check_output("halted", {63'd0, halted}, {63'd0, m_halted});
    check_output("illegal_op", {63'd0, illegal_op}, {63'd0, m_illegal});
    check_output("issued_count", {48'd0, issued_count}, {48'd0, m_issued[15:0]});
  endtask

  task automatic idle(input int cycles, input logic ordy);
    for (int i = 0; i < cycles; i++) apply_stimulus(1'b0, 64'd0, ordy, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int pushed;
    in_valid       = 1'b0;
    in_instruction = '0;
    out_ready      = 1'b0;
    resume         = 1'b0;
    reset_n        = 1'b0;
    @(negedge clk);

    // Reset values
    do_reset();
    check_output("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("rst_issued", {48'd0, issued_count}, 64'd0);
    apply_stimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    check_output("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Single COMPUTE: two-cycle latency, fields, one issue
    apply_stimulus(1'b1, make_word(OPC_COMPUTE, 16'h0010, 16'h0020, 16'd8), 1'b1, 1'b0, 1'b1);
    check_output("lat_not_yet", {63'd0, out_valid}, 64'd0);
    apply_stimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    check_output("lat_valid", {63'd0, out_valid}, 64'd1);
    check_output("lat_opcode", {60'd0, out_opcode}, 64'h3);
    check_output("lat_addr_a", {48'd0, out_addr_a}, 64'h10);
    check_output("lat_addr_b", {48'd0, out_addr_b}, 64'h20);
    check_output("lat_count", {48'd0, out_count}, 64'd8);
    apply_stimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    check_output("lat_issued", {48'd0, issued_count}, 64'd1);

    // Fill with sequencer stalled: FIFO plus output register hold five words
    do_reset();
    pushed = 0;
    for (int i = 0; i < 10 && pushed < DEPTH + 1; i++) begin
      if (model_in_ready(1'b1)) pushed++;
      apply_stimulus(1'b1, make_word(4'(1 + i % 4), 16'(i), 16'(100 + i), 16'(i * 3)), 1'b0, 1'b0, 1'b1);
    end
    check_output("full_in_ready", {63'd0, in_ready}, 64'd0);
    apply_stimulus(1'b1, make_word(OPC_STORE, 16'hDEAD, 16'hBEEF, 16'h1), 1'b0, 1'b0, 1'b1);
    idle(6, 1'b1);
    check_output("full_drained", {48'd0, issued_count}, 64'd5);
    check_output("full_idle_valid", {63'd0, out_valid}, 64'd0);

    // NOP, LOAD_DATA, illegal 0x7, STORE
    do_reset();
    apply_stimulus(1'b1, make_word(OPC_NOP, 16'h1, 16'h2, 16'h3), 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, make_word(OPC_LOAD_D, 16'h11, 16'h22, 16'h33), 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, make_word(4'h7, 16'h44, 16'h55, 16'h66), 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, make_word(OPC_STORE, 16'h77, 16'h88, 16'h99), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    check_output("mix_illegal", {63'd0, illegal_op}, 64'd1);
    check_output("mix_issued", {48'd0, issued_count}, 64'd2);

    // HALT then LOAD_WEIGHT; resume releases it
    do_reset();
    apply_stimulus(1'b1, make_word(OPC_HALT, 16'h0, 16'h0, 16'h0), 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, make_word(OPC_LOAD_W, 16'hA5A5, 16'h5A5A, 16'h0040), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    check_output("halt_halted", {63'd0, halted}, 64'd1);
    check_output("halt_issued", {48'd0, issued_count}, 64'd0);
    check_output("halt_in_ready", {63'd0, in_ready}, 64'd0);
    apply_stimulus(1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1);
    check_output("resume_halted", {63'd0, halted}, 64'd0);
    check_output("resume_issued", {48'd0, issued_count}, 64'd1);
    check_output("resume_addr_a", {48'd0, out_addr_a}, 64'hA5A5);

    // Reset with three buffered entries and a stalled command
    do_reset();
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b1, make_word(OPC_LOAD_D, 16'(i), 16'(i), 16'(i)), 1'b0, 1'b0, 1'b1);
    check_output("midrst_pre_valid", {63'd0, out_valid}, 64'd1);
    apply_stimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    check_output("midrst_valid", {63'd0, out_valid}, 64'd0);
    check_output("midrst_issued", {48'd0, issued_count}, 64'd0);
    idle(3, 1'b1);
    check_output("midrst_empty_valid", {63'd0, out_valid}, 64'd0);
    check_output("midrst_empty_issued", {48'd0, issued_count}, 64'd0);

    // Randomized traffic with occasional resume pulses and resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 4));
      apply_stimulus(1'($urandom_range(0, 2) != 0),
                     make_word(op, 16'($urandom), 16'($urandom), 16'($urandom)),
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 199) != 0));
    end

    // Stream 65536 issuable words at full rate: the counter wraps to zero
    do_reset();
    for (int i = 0; i < 65536; i++)
      apply_stimulus(1'b1, make_word(4'(1 + i % 4), 16'(i), 16'(~i), 16'(i ^ 16'h5555)), 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    check_output("wrap_issued", {48'd0, issued_count}, 64'd0);
    check_output("wrap_valid", {63'd0, out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
